ahb_lite_burst_master: RTL and testbench
========================================

Name: ahb_lite_burst_master

Overview:
- Master-side sequencer for the AHB-Lite bus used by the slave under test.
- Accepts one transfer command at a time: address, direction, size, burst type and length.
- Drives the AHB-Lite address/control phase (IDLE/NONSEQ/SEQ), handles the pipelined data phase, HREADY wait states and the two-cycle ERROR response.
- Returns read data and per-beat write-data pops to a local client.

Parameters:
- ADDRWIDTH, 32, width of HADDR and cmd_addr.
- DATAWIDTH, 32, width of HWDATA/HRDATA/wr_data/rd_data.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  synchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge.
- cmd_addr  input  ADDRWIDTH  start byte address.
- cmd_write  input  1  1=write, 0=read.
- cmd_size  input  3  HSIZE encoding; 0..2 legal (byte/half/word).
- cmd_burst  input  3  0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16.
- cmd_len  input  5  beat count for INCR only, 1..16; 0 treated as 1.
- wr_data  input  DATAWIDTH  write data for current write data phase.
- wr_pop  output  1  pulse: current write beat consumed.
- rd_data  output  DATAWIDTH  captured HRDATA.
- rd_valid  output  1  pulse: rd_data valid.
- done  output  1  pulse: command finished.
- err  output  1  pulse with done when terminated by ERROR.
- HADDR  output  ADDRWIDTH  address phase address.
- HTRANS  output  2  0 IDLE, 2 NONSEQ, 3 SEQ; BUSY is never issued.
- HWRITE  output  1  direction.
- HSIZE  output  3  transfer size.
- HBURST  output  3  burst type.
- HMASTLOCK  output  1  tied 0.
- HPROT  output  4  constant 4'b0011.
- HWDATA  output  DATAWIDTH  = wr_data during a write data phase, else 0.
- HRDATA  input  DATAWIDTH  slave read data.
- HREADY  input  1  transfer done / wait.
- HRESP  input  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (HRESETn=0 at edge):
  - State IDLE; HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0.
  - rd_data=0; rd_valid, wr_pop, done, err = 0; cmd_ready=0 during reset.
  - Reset mid-burst abandons the command; no done is produced.
- States: IDLE, ADDR, DATA_LAST, ERR2.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch the command; next cycle enter ADDR with HTRANS=NONSEQ and HADDR=cmd_addr with low log2(bytes) bits cleared.
- Beat count:
  - SINGLE=1.
  - INCR=cmd_len.
  - WRAPn/INCRn = n.
- ADDR:
  - Address/control hold while HREADY=0.
  - On HREADY=1 the current beat moves to data phase.
  - If beats remain, drive SEQ with the next address. Increment is 1<<HSIZE.
  - WRAP bursts: boundary = beats*bytes; next = (addr & ~(bound-1)) | ((addr+inc) & (bound-1)).
  - INCR/INCRn crossing a 1KB boundary: issue that beat as NONSEQ with HBURST=INCR; later beats are SEQ.
  - After the last address phase is accepted, drive HTRANS=IDLE and go to DATA_LAST.
- Data phase completion (HREADY=1, HRESP=0):
  - Write: wr_pop=1 for one cycle.
  - Read: rd_data<=HRDATA and rd_valid=1 the following cycle.
  - wr_data must be valid throughout each write data phase.
- DATA_LAST: when the final data phase completes OKAY, done pulses next cycle, then return to IDLE. Earliest next command: NONSEQ 2 cycles after done.
- ERROR (HRESP=1 with HREADY=0, first cycle):
  - Master drives HTRANS=IDLE in the next cycle (ERR2), cancelling any pending address.
  - No wr_pop/rd_valid for the errored beat.
  - When HREADY=1 and HRESP=1 (second cycle), done and err pulse the next cycle, then IDLE.
  - Remaining beats are dropped.
- Throughput: zero-wait-state burst of N beats completes N data phases in N consecutive cycles.
- cmd_size>2: command accepted, executed with HSIZE=2.

Test Plan:
- SINGLE write, addr 0x100, word, HREADY=1 -> cycle+1: NONSEQ 0x100 HWRITE=1; cycle+2: HTRANS=IDLE, HWDATA=wr_data, wr_pop=1; done pulses cycle+3.
- INCR4 read 0x40 word, slave holds HREADY=0 for 2 cycles on beat 2 -> HADDR 0x40,0x44,0x48,0x4C; SEQ held at 0x48 during waits; 4 rd_valid pulses in order; one done.
- WRAP8 word from 0x34 -> HADDR 0x34,0x38,0x3C,0x20,0x24,0x28,0x2C,0x30; first NONSEQ, rest SEQ.
- INCR cmd_len=4 word from 0x3F8 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- INCR8 write, ERROR on beat 3 -> HTRANS=IDLE in 2nd error cycle; exactly 2 wr_pop; done=err=1 together; no further address phases.
- HRESETn=0 during beat 2 of INCR16 -> next cycle HTRANS=0, HADDR=0, no done; cmd_ready=1 after release.

Source files
------------

// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite master sequencer: takes one burst command at a time, drives the
// pipelined address/data phases and reports read data, write pops and completion.
module ahb_lite_burst_master #(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic                 cmd_write,
  input  logic [2:0]           cmd_size,
  input  logic [2:0]           cmd_burst,
  input  logic [4:0]           cmd_len,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 wr_pop,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 err,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic                 HMASTLOCK,
  output logic [3:0]           HPROT,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic [DATAWIDTH-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  localparam int unsigned KB_BIT = 10;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA_LAST, S_ERR2} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDRWIDTH-1:0] r_haddr, w_haddr_nxt;
  logic [1:0]           r_htrans, w_htrans_nxt;
  logic                 r_hwrite, w_hwrite_nxt;
  logic [2:0]           r_hsize, w_hsize_nxt;
  logic [2:0]           r_hburst, w_hburst_nxt;
  logic [2:0]           r_btype, w_btype_nxt;
  logic [4:0]           r_nbeats, w_nbeats_nxt;
  logic [4:0]           r_left, w_left_nxt;
  logic                 r_dp_valid, w_dp_valid_nxt;
  logic                 r_dp_write, w_dp_write_nxt;
  logic                 r_cmd_ready, w_cmd_ready_nxt;
  logic [DATAWIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic                 r_rd_valid, w_rd_valid_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;

  logic                 w_handshake;
  logic                 w_dp_ok;
  logic                 w_dp_err1;
  logic [2:0]           w_cmd_size;
  logic [4:0]           w_cmd_beats;
  logic [ADDRWIDTH-1:0] w_cmd_mask;
  logic [ADDRWIDTH-1:0] w_inc;
  logic [ADDRWIDTH-1:0] w_bound_mask;
  logic [ADDRWIDTH-1:0] w_addr_inc;
  logic [ADDRWIDTH-1:0] w_addr_next;
  logic                 w_wrap;
  logic                 w_cross_kb;

  assign w_handshake = cmd_valid && r_cmd_ready;
  assign w_cmd_size  = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
  assign w_cmd_mask  = ~((ADDRWIDTH'(1) << w_cmd_size) - ADDRWIDTH'(1));

  // Beat count of the incoming command
  always_comb begin
    w_cmd_beats = 5'd1;
    case (cmd_burst)
      3'd0:       w_cmd_beats = 5'd1;
      3'd1:       w_cmd_beats = (cmd_len == 5'd0) ? 5'd1 :
                                (cmd_len > 5'd16) ? 5'd16 : cmd_len;
      3'd2, 3'd3: w_cmd_beats = 5'd4;
      3'd4, 3'd5: w_cmd_beats = 5'd8;
      default:    w_cmd_beats = 5'd16;
    endcase
  end

  // Next beat address; wrapping bursts stay inside a beats*bytes window
  assign w_inc        = ADDRWIDTH'(1) << r_hsize;
  assign w_bound_mask = (ADDRWIDTH'(r_nbeats) << r_hsize) - ADDRWIDTH'(1);
  assign w_addr_inc   = r_haddr + w_inc;
  assign w_wrap       = (r_btype != 3'd0) && !r_btype[0];
  assign w_addr_next  = w_wrap ? ((r_haddr & ~w_bound_mask) | (w_addr_inc & w_bound_mask))
                               : w_addr_inc;
  assign w_cross_kb   = !w_wrap &&
                        (w_addr_next[ADDRWIDTH-1:KB_BIT] != r_haddr[ADDRWIDTH-1:KB_BIT]);

  assign w_dp_ok   = r_dp_valid && HREADY && !HRESP && (r_state != S_ERR2);
  assign w_dp_err1 = r_dp_valid && !HREADY && HRESP &&
                     ((r_state == S_ADDR) || (r_state == S_DATA_LAST));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_htrans    <= TR_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'd0;
      r_hburst    <= 3'd0;
      r_btype     <= 3'd0;
      r_nbeats    <= 5'd0;
      r_left      <= 5'd0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_haddr     <= w_haddr_nxt;
      r_htrans    <= w_htrans_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hsize     <= w_hsize_nxt;
      r_hburst    <= w_hburst_nxt;
      r_btype     <= w_btype_nxt;
      r_nbeats    <= w_nbeats_nxt;
      r_left      <= w_left_nxt;
      r_dp_valid  <= w_dp_valid_nxt;
      r_dp_write  <= w_dp_write_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_haddr_nxt    = r_haddr;
    w_htrans_nxt   = r_htrans;
    w_hwrite_nxt   = r_hwrite;
    w_hsize_nxt    = r_hsize;
    w_hburst_nxt   = r_hburst;
    w_btype_nxt    = r_btype;
    w_nbeats_nxt   = r_nbeats;
    w_left_nxt     = r_left;
    w_dp_valid_nxt = r_dp_valid;
    w_dp_write_nxt = r_dp_write;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    // Registered ready keeps a one-cycle gap after done before the next accept
    w_cmd_ready_nxt = (r_state == S_IDLE) && !w_handshake;

    if (w_dp_ok && !r_dp_write) begin
      w_rd_valid_nxt = 1'b1;
      w_rd_data_nxt  = HRDATA;
    end

    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_state_nxt    = S_ADDR;
          w_htrans_nxt   = TR_NONSEQ;
          w_haddr_nxt    = cmd_addr & w_cmd_mask;
          w_hwrite_nxt   = cmd_write;
          w_hsize_nxt    = w_cmd_size;
          w_hburst_nxt   = cmd_burst;
          w_btype_nxt    = cmd_burst;
          w_nbeats_nxt   = w_cmd_beats;
          w_left_nxt     = w_cmd_beats - 5'd1;
          w_dp_valid_nxt = 1'b0;
        end
      end
      S_ADDR: begin
        if (w_dp_err1) begin
          w_htrans_nxt = TR_IDLE;
          w_state_nxt  = S_ERR2;
        end else if (HREADY) begin
          w_dp_valid_nxt = 1'b1;
          w_dp_write_nxt = r_hwrite;
          if (r_left != 5'd0) begin
            w_left_nxt  = r_left - 5'd1;
            w_haddr_nxt = w_addr_next;
            if (w_cross_kb) begin
              w_htrans_nxt = TR_NONSEQ;
              w_hburst_nxt = BU_INCR;
            end else begin
              w_htrans_nxt = TR_SEQ;
            end
          end else begin
            w_htrans_nxt = TR_IDLE;
            w_state_nxt  = S_DATA_LAST;
          end
        end
      end
      S_DATA_LAST: begin
        if (w_dp_err1) begin
          w_state_nxt = S_ERR2;
        end else if (HREADY) begin
          w_dp_valid_nxt = 1'b0;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          w_dp_valid_nxt = 1'b0;
          w_done_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign wr_pop    = w_dp_ok && r_dp_write;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign err       = r_err;
  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HBURST    = r_hburst;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign HWDATA    = (r_dp_valid && r_dp_write) ? wr_data : '0;

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Scoreboard bench: expected address phases and read data are queued per
// command and retired as the bus model observes the master.
module tb_ahb_lite_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size, cmd_burst;
  logic [4:0]  cmd_len;
  logic [31:0] wr_data, rd_data, HADDR, HWDATA, HRDATA;
  logic        wr_pop, rd_valid, done, err;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  t;
    logic [2:0]  b;
  } beat_t;

  beat_t       aq[$];
  logic [31:0] rq[$];

  ahb_lite_burst_master #(.ADDRWIDTH(32), .DATAWIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_len(cmd_len), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_beat(input logic [31:0] a, input logic [1:0] t, input logic [2:0] bu);
    beat_t x;
    x.a = a; x.t = t; x.b = bu;
    aq.push_back(x);
  endtask

  task automatic push_rd(input logic [31:0] a);
    rq.push_back(rdf(a));
  endtask

  // Issue one command and play the slave; indices are 0-based data-phase numbers
  task automatic run_cmd(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [2:0] burst, input logic [4:0] len,
                         input int exp_size, input int exp_pops, input int exp_err,
                         input int exp_done_cyc, input int wait_beat, input int wait_n,
                         input int err_beat, input int rst_cyc);
    int cyc, dp_idx, wait_left, npop, n;
    logic dp_act, dp_wr, err_ph, fin, exp_pop;
    logic [31:0] dp_a;
    beat_t b;
    cyc = 0; dp_idx = 0; wait_left = 0; npop = 0; n = 0;
    dp_act = 1'b0; dp_wr = 1'b0; err_ph = 1'b0; fin = 1'b0; dp_a = '0;

    @(negedge HCLK);
    cmd_addr = addr; cmd_write = wr; cmd_size = size; cmd_burst = burst; cmd_len = len;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 50) begin
      @(negedge HCLK); #1; n++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;

    while (!fin && cyc < 100) begin
      @(negedge HCLK);
      cyc++;
      HREADY = 1'b1; HRESP = 1'b0;
      if (dp_act) begin
        if (dp_idx == err_beat) begin
          HRESP = 1'b1;
          if (!err_ph) begin HREADY = 1'b0; err_ph = 1'b1; end
        end else if (wait_left > 0) begin
          HREADY = 1'b0; wait_left--;
        end
      end
      HRDATA  = (dp_act && !dp_wr) ? rdf(dp_a) : 32'h0;
      wr_data = 32'hC0DE_0000 + 32'(dp_idx);
      #1;

      if (HREADY && HRESP) check_eq("err2_idle", 32'(HTRANS), 32'd0);
      if (rd_valid) begin
        if (rq.size() == 0) check_eq("rd_extra", 32'(rd_valid), 32'd0);
        else check_eq("rd_data", rd_data, rq.pop_front());
      end
      exp_pop = dp_act && dp_wr && HREADY && !HRESP;
      if (wr_pop || exp_pop) check_eq("wr_pop", 32'(wr_pop), 32'(exp_pop));
      if (exp_pop) begin
        check_eq("hwdata", HWDATA, wr_data);
        npop++;
      end
      if (HTRANS != 2'b00) begin
        if (!HREADY) begin
          if (aq.size() != 0) check_eq("addr_hold", HADDR, aq[0].a);
        end else if (aq.size() == 0) begin
          check_eq("extra_addr", 32'(HTRANS), 32'd0);
        end else begin
          b = aq.pop_front();
          check_eq("haddr", HADDR, b.a);
          check_eq("htrans", 32'(HTRANS), 32'(b.t));
          check_eq("hburst", 32'(HBURST), 32'(b.b));
          check_eq("hsize", 32'(HSIZE), 32'(exp_size));
          check_eq("hwrite", 32'(HWRITE), 32'(wr));
        end
      end
      if (done) begin
        check_eq("err", 32'(err), 32'(exp_err));
        if (exp_done_cyc > 0) check_eq("done_cyc", 32'(cyc), 32'(exp_done_cyc));
        check_eq("rdy_at_done", 32'(cmd_ready), 32'd0);
        fin = 1'b1;
      end else if (err) begin
        check_eq("err_wo_done", 32'(err), 32'd0);
      end

      if (cyc == rst_cyc) begin
        HRESETn = 1'b0;
        @(negedge HCLK); #1;
        check_eq("rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("rst_haddr", HADDR, 32'h0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rdy", 32'(cmd_ready), 32'd0);
        check_eq("rst_rdv", 32'(rd_valid), 32'd0);
        HRESETn = 1'b1;
        HREADY  = 1'b1; HRESP = 1'b0;
        @(negedge HCLK); #1;
        check_eq("rel_rdy", 32'(cmd_ready), 32'd1);
        check_eq("rel_done", 32'(done), 32'd0);
        aq.delete(); rq.delete();
        return;
      end

      if (HREADY) begin
        if (dp_act) dp_idx++;
        dp_act = (HTRANS != 2'b00);
        dp_a   = HADDR;
        dp_wr  = HWRITE;
        err_ph = 1'b0;
        if (dp_act && dp_idx == wait_beat) wait_left = wait_n;
      end
    end

    if (!fin) check_eq("done_timeout", 32'(done), 32'd1);
    check_eq("npop", 32'(npop), 32'(exp_pops));
    check_eq("rd_left", 32'(rq.size()), 32'd0);
    check_eq("addr_left", 32'(aq.size()), 32'd0);
    aq.delete(); rq.delete();
    HREADY = 1'b1; HRESP = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_size = '0; cmd_burst = '0; cmd_len = '0; wr_data = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

    repeat (3) @(negedge HCLK);
    #1;
    check_eq("rst_htrans0", 32'(HTRANS), 32'd0);
    check_eq("rst_haddr0", HADDR, 32'h0);
    check_eq("rst_rdy0", 32'(cmd_ready), 32'd0);
    check_eq("rst_rddata0", rd_data, 32'h0);
    check_eq("rst_flags0", {28'h0, rd_valid, wr_pop, done, err}, 32'h0);
    check_eq("hprot", 32'(HPROT), 32'h3);
    check_eq("hmastlock", 32'(HMASTLOCK), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK); #1;
    check_eq("rel_rdy0", 32'(cmd_ready), 32'd1);

    // SINGLE word write
    push_beat(32'h100, 2'b10, 3'd0);
    run_cmd(32'h100, 1'b1, 3'd2, 3'd0, 5'd0, 2, 1, 0, 3, -1, 0, -1, -1);

    // INCR4 read, two wait states on the second data phase
    push_beat(32'h40, 2'b10, 3'd3); push_beat(32'h44, 2'b11, 3'd3);
    push_beat(32'h48, 2'b11, 3'd3); push_beat(32'h4C, 2'b11, 3'd3);
    push_rd(32'h40); push_rd(32'h44); push_rd(32'h48); push_rd(32'h4C);
    run_cmd(32'h40, 1'b0, 3'd2, 3'd3, 5'd0, 2, 0, 0, 8, 1, 2, -1, -1);

    // WRAP8 word write from 0x34
    push_beat(32'h34, 2'b10, 3'd4); push_beat(32'h38, 2'b11, 3'd4);
    push_beat(32'h3C, 2'b11, 3'd4); push_beat(32'h20, 2'b11, 3'd4);
    push_beat(32'h24, 2'b11, 3'd4); push_beat(32'h28, 2'b11, 3'd4);
    push_beat(32'h2C, 2'b11, 3'd4); push_beat(32'h30, 2'b11, 3'd4);
    run_cmd(32'h34, 1'b1, 3'd2, 3'd4, 5'd0, 2, 8, 0, 10, -1, 0, -1, -1);

    // INCR length 4 crossing a 1KB boundary
    push_beat(32'h3F8, 2'b10, 3'd1); push_beat(32'h3FC, 2'b11, 3'd1);
    push_beat(32'h400, 2'b10, 3'd1); push_beat(32'h404, 2'b11, 3'd1);
    push_rd(32'h3F8); push_rd(32'h3FC); push_rd(32'h400); push_rd(32'h404);
    run_cmd(32'h3F8, 1'b0, 3'd2, 3'd1, 5'd4, 2, 0, 0, 6, -1, 0, -1, -1);

    // INCR8 write with ERROR on the third beat
    push_beat(32'h200, 2'b10, 3'd5); push_beat(32'h204, 2'b11, 3'd5);
    push_beat(32'h208, 2'b11, 3'd5);
    run_cmd(32'h200, 1'b1, 3'd2, 3'd5, 5'd0, 2, 2, 1, 6, -1, 0, 2, -1);

    // Oversized HSIZE clamps to word, address aligned
    push_beat(32'h104, 2'b10, 3'd0); push_rd(32'h104);
    run_cmd(32'h107, 1'b0, 3'd3, 3'd0, 5'd0, 2, 0, 0, 3, -1, 0, -1, -1);

    // INCR with len 0 behaves as one halfword beat
    push_beat(32'h202, 2'b10, 3'd1);
    run_cmd(32'h203, 1'b1, 3'd1, 3'd1, 5'd0, 1, 1, 0, 3, -1, 0, -1, -1);

    // Reset during beat 2 of an INCR16 read
    push_beat(32'h300, 2'b10, 3'd7); push_beat(32'h304, 2'b11, 3'd7);
    push_beat(32'h308, 2'b11, 3'd7); push_rd(32'h300);
    run_cmd(32'h300, 1'b0, 3'd2, 3'd7, 5'd0, 2, 0, 0, -1, -1, 0, -1, 3);

    // Recovery after reset
    push_beat(32'h10, 2'b10, 3'd0); push_rd(32'h10);
    run_cmd(32'h10, 1'b0, 3'd2, 3'd0, 5'd0, 2, 0, 0, 3, -1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
